mcf_bst_issuer: RTL and testbench

Front-end burst issuer: the requesting end of the memory-controller back-end command interface. Accepts one host transfer request of up to 2^LEN_W bursts, splits it into back-end requests of 1–4 bursts, and issues each as a one-cycle `mcb_bb` pulse with `mcb_wr_n`/`mcb_bl`/`mcb_addr`. It issues a pulse only when the back-end reports `mcb_busy` low. It sits between the host bus adapter and the back-end command controller.

---
 rtl/mcf_bst_issuer.sv | 215 +++++++++++++++++++++
 tb/tb_mcf_bst_issuer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcf_bst_issuer.sv
// -----------------------------------------------------------------------------
// mcf_bst_issuer
//
// Requesting end of the memory-controller back-end command interface. One host
// transfer of up to 2^LEN_W bursts is accepted in IDLE. It is cut into
// back-end requests of 1..4 bursts. Each request goes out as a single-cycle
// mcb_bb pulse carrying mcb_wr_n / mcb_bl / mcb_addr. A pulse is only launched
// from a WAIT cycle in which the back-end reports mcb_busy low.
//
// Optional feature macro: MCF_ROW_SPLIT_EN
//   When it is defined, a request is also trimmed so that it never crosses a
//   row boundary. A row is 2^COL_W words. When it is undefined, the row logic
//   is absent and COL_W is unused.
//
// Parameters
//   ADDR_W     word address width; addresses wrap modulo 2^ADDR_W
//   LEN_W      width of the host burst-count field
//   BST_WORDS  words per SDRAM burst (power of two); address step per burst
//   COL_W      column address bits (row split only)
//
// Ports
//   mcb_clk     in   clock, rising edge
//   mcb_rst_n   in   synchronous active-low reset
//   mcb_sclr_n  in   synchronous active-low soft clear, same effect as reset
//   h_req       in   host request, looked at only in IDLE
//   h_wr_n      in   0 = write, 1 = read
//   h_addr      in   start word address, BST_WORDS aligned
//   h_len       in   burst count minus 1
//   h_ack       out  one-cycle pulse, request accepted
//   h_done      out  one-cycle pulse, last back-end request issued
//   h_busy      out  high whenever the issuer is not idle
//   mcb_busy    in   back-end busy (may depend combinationally on mcb_bb)
//   mcb_bb      out  registered burst-begin pulse
//   mcb_wr_n    out  direction of the current request
//   mcb_bl      out  bursts in the current request minus 1
//   mcb_addr    out  start address of the current request
// -----------------------------------------------------------------------------
module mcf_bst_issuer #(
  parameter int ADDR_W    = 22,
  parameter int LEN_W     = 8,
  parameter int BST_WORDS = 4,
  parameter int COL_W     = 8
) (
  input  logic              mcb_clk,
  input  logic              mcb_rst_n,
  input  logic              mcb_sclr_n,
  input  logic              h_req,
  input  logic              h_wr_n,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [LEN_W-1:0]  h_len,
  output logic              h_ack,
  output logic              h_done,
  output logic              h_busy,
  input  logic              mcb_busy,
  output logic              mcb_bb,
  output logic              mcb_wr_n,
  output logic [1:0]        mcb_bl,
  output logic [ADDR_W-1:0] mcb_addr
);

  localparam int BST_SH = $clog2(BST_WORDS);
  localparam int REM_W  = LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_POST
  } state_t;

  state_t            state_q,    state_d;
  logic [REM_W-1:0]  rem_q,      rem_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              dir_q,      dir_d;
  logic              mcb_bb_q,   mcb_bb_d;
  logic              mcb_wr_n_q, mcb_wr_n_d;
  logic [1:0]        mcb_bl_q,   mcb_bl_d;
  logic [ADDR_W-1:0] mcb_addr_q, mcb_addr_d;
  logic              h_ack_q,    h_ack_d;
  logic              h_done_q,   h_done_d;

  logic [2:0] chunk_rem;
  logic [2:0] chunk;
  logic [2:0] issued;

  // Chunk limited by the bursts still owed: min(rem, 4). rem is never 0 in
  // WAIT, so the result is always 1..4.
  always_comb begin
    chunk_rem = rem_q[2:0];
    if (rem_q >= REM_W'(4)) begin
      chunk_rem = 3'd4;
    end
  end

`ifdef MCF_ROW_SPLIT_EN
  localparam logic [COL_W:0] ROW_WORDS = (COL_W+1)'(1) << COL_W;

  logic [COL_W:0] row_left;
  logic [COL_W:0] row_bursts;

  // Whole bursts left before the end of the current row. The start address is
  // burst aligned, so this is at least 1 and never truncates a partial burst.
  assign row_left   = ROW_WORDS - {1'b0, cur_addr_q[COL_W-1:0]};
  assign row_bursts = row_left >> BST_SH;

  // Final chunk is the smaller of the remaining-length limit and the row limit.
  always_comb begin
    chunk = chunk_rem;
    if (row_bursts < (COL_W+1)'(chunk_rem)) begin
      chunk = row_bursts[2:0];
    end
  end
`else
  assign chunk = chunk_rem;
`endif

  // mcb_bl still holds chunk-1 from the WAIT cycle while in ISSUE. It is
  // reused here to advance rem and cur_addr, so no separate chunk register
  // is needed.
  assign issued = {1'b0, mcb_bl_q} + 3'd1;

  // Next-state and output logic. Every register holds by default. h_ack,
  // h_done and mcb_bb default low, so each of them is a one-cycle pulse.
  // mcb_busy is consulted only in WAIT, where mcb_bb is known to be low.
  // That keeps the back-end's combinational busy path free of a loop.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cur_addr_d = cur_addr_q;
    dir_d      = dir_q;
    mcb_bb_d   = 1'b0;
    mcb_wr_n_d = mcb_wr_n_q;
    mcb_bl_d   = mcb_bl_q;
    mcb_addr_d = mcb_addr_q;
    h_ack_d    = 1'b0;
    h_done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (h_req) begin
          rem_d      = REM_W'(h_len) + REM_W'(1);
          cur_addr_d = h_addr;
          dir_d      = h_wr_n;
          h_ack_d    = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mcb_busy) begin
          mcb_bb_d   = 1'b1;
          mcb_bl_d   = 2'(chunk - 3'd1);
          mcb_addr_d = cur_addr_q;
          mcb_wr_n_d = dir_q;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rem_d      = rem_q - REM_W'(issued);
        cur_addr_d = cur_addr_q + (ADDR_W'(issued) << BST_SH);
        state_d    = ST_POST;
      end
      ST_POST: begin
        // Guard cycle: the back-end's ready register settles before the
        // next WAIT cycle looks at mcb_busy again.
        if (rem_q == '0) begin
          h_done_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Hard reset and soft clear have the same
  // effect and override everything, including a transfer in flight. No
  // h_done is produced for an aborted transfer.
  always_ff @(posedge mcb_clk) begin
    if (!mcb_rst_n || !mcb_sclr_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      cur_addr_q <= '0;
      dir_q      <= 1'b1;
      mcb_bb_q   <= 1'b0;
      mcb_wr_n_q <= 1'b1;
      mcb_bl_q   <= 2'd0;
      mcb_addr_q <= '0;
      h_ack_q    <= 1'b0;
      h_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cur_addr_q <= cur_addr_d;
      dir_q      <= dir_d;
      mcb_bb_q   <= mcb_bb_d;
      mcb_wr_n_q <= mcb_wr_n_d;
      mcb_bl_q   <= mcb_bl_d;
      mcb_addr_q <= mcb_addr_d;
      h_ack_q    <= h_ack_d;
      h_done_q   <= h_done_d;
    end
  end

  assign h_ack    = h_ack_q;
  assign h_done   = h_done_q;
  assign h_busy   = (state_q != ST_IDLE);
  assign mcb_bb   = mcb_bb_q;
  assign mcb_wr_n = mcb_wr_n_q;
  assign mcb_bl   = mcb_bl_q;
  assign mcb_addr = mcb_addr_q;

endmodule

// File: tb/tb_mcf_bst_issuer.sv
// -----------------------------------------------------------------------------
// tb_mcf_bst_issuer
//
// Self-checking bench for mcf_bst_issuer.
// - A table of directed transfers is checked against hand-derived constants.
// - Hand-written sequences cover soft clear, hard reset and requests that
//   arrive while the issuer is busy.
// - Randomized transfers with random back-end busy are checked against a
//   burst-splitting reference model.
// -----------------------------------------------------------------------------
module tb_mcf_bst_issuer;

  localparam int ADDR_W    = 22;
  localparam int LEN_W     = 8;
  localparam int BST_WORDS = 4;
  localparam int COL_W     = 8;

  logic              mcb_clk = 1'b0;
  logic              mcb_rst_n;
  logic              mcb_sclr_n;
  logic              h_req;
  logic              h_wr_n;
  logic [ADDR_W-1:0] h_addr;
  logic [LEN_W-1:0]  h_len;
  logic              h_ack;
  logic              h_done;
  logic              h_busy;
  logic              mcb_busy;
  logic              mcb_bb;
  logic              mcb_wr_n;
  logic [1:0]        mcb_bl;
  logic [ADDR_W-1:0] mcb_addr;

  mcf_bst_issuer #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .BST_WORDS(BST_WORDS),
    .COL_W    (COL_W)
  ) dut (
    .mcb_clk   (mcb_clk),
    .mcb_rst_n (mcb_rst_n),
    .mcb_sclr_n(mcb_sclr_n),
    .h_req     (h_req),
    .h_wr_n    (h_wr_n),
    .h_addr    (h_addr),
    .h_len     (h_len),
    .h_ack     (h_ack),
    .h_done    (h_done),
    .h_busy    (h_busy),
    .mcb_busy  (mcb_busy),
    .mcb_bb    (mcb_bb),
    .mcb_wr_n  (mcb_wr_n),
    .mcb_bl    (mcb_bl),
    .mcb_addr  (mcb_addr)
  );

  // Free-running clock
  always #5 mcb_clk = ~mcb_clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int reqCyc      = 0;

  typedef struct {
    int                cyc;
    logic [1:0]        bl;
    logic [ADDR_W-1:0] addr;
    logic              wrN;
  } pulse_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              wrN;
    int                busyCycles;
    int                expPulses;
    logic [1:0]        expFirstBl;
    logic [ADDR_W-1:0] expFirstAddr;
    logic [1:0]        expLastBl;
    logic [ADDR_W-1:0] expLastAddr;
    int                expAckToDone;
  } vec_t;

  pulse_t pulses[$];
  int     ackCyc[$];
  int     ackBusy[$];
  int     doneCyc[$];
  int     doneBusy[$];
  bit     busyAt[int];
  int     expBl[$];
  longint expAddr[$];
  vec_t   vecs[$];

  // Cycle counter, used to time-stamp every observed event
  always @(posedge mcb_clk) cyc <= cyc + 1;

  // Event logger, sampling mid-cycle well away from the active edge
  always @(negedge mcb_clk) begin
    if (mcb_bb === 1'b1) pulses.push_back(pulse_t'{cyc, mcb_bl, mcb_addr, mcb_wr_n});
    if (h_ack === 1'b1) begin
      ackCyc.push_back(cyc);
      ackBusy.push_back(int'(h_busy));
    end
    if (h_done === 1'b1) begin
      doneCyc.push_back(cyc);
      doneBusy.push_back(int'(h_busy));
    end
  end

  // Advance to just after the next falling edge, so the logger has already
  // run and input changes land mid-cycle
  task automatic step();
    @(negedge mcb_clk);
    #1;
  endtask

  task automatic clearLogs();
    pulses.delete();
    ackCyc.delete();
    ackBusy.delete();
    doneCyc.delete();
    doneBusy.delete();
    busyAt.delete();
  endtask

  // One comparison: count it and report it if it differs
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Back-end busy for the current cycle, either random or held high for
  // busyCycles cycles starting from the acknowledge cycle
  task automatic driveBusy(input bit randBusy, input int busyCycles);
    if (randBusy) mcb_busy = ($urandom_range(0, 2) == 0);
    else          mcb_busy = (cyc < reqCyc + 1 + busyCycles);
    busyAt[cyc] = mcb_busy;
  endtask

  // Present one host request, then run until h_done or a cycle budget ends.
  // The host fields are scrambled after the sampling cycle.
  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                               input logic wr, input int busyCycles, input bit randBusy);
    int budget;
    clearLogs();
    h_req  = 1'b1;
    h_addr = a;
    h_len  = len;
    h_wr_n = wr;
    reqCyc = cyc;
    driveBusy(randBusy, busyCycles);
    step();
    h_req  = 1'b0;
    h_addr = ADDR_W'($urandom);
    h_len  = LEN_W'($urandom);
    h_wr_n = 1'($urandom_range(0, 1));
    budget = 0;
    while (doneCyc.size() == 0 && budget < 3000) begin
      driveBusy(randBusy, busyCycles);
      step();
      budget++;
    end
    checkOutput("doneSeen", 64'(doneCyc.size() > 0), 64'd1);
    repeat (3) begin
      driveBusy(randBusy, busyCycles);
      step();
    end
    mcb_busy = 1'b0;
  endtask

  // Reference split of a transfer into back-end requests, straight from the
  // splitting rules: take up to 4 bursts, never past the row end when row
  // splitting is enabled, and wrap the address modulo 2^ADDR_W
  task automatic buildModel(input logic [ADDR_W-1:0] a, input int len);
    longint addr;
    int     remain;
    int     c;
    int     room;
    addr   = longint'(a);
    remain = len + 1;
    expBl.delete();
    expAddr.delete();
    while (remain > 0) begin
      c = (remain < 4) ? remain : 4;
`ifdef MCF_ROW_SPLIT_EN
      room = ((1 << COL_W) - int'(addr % (longint'(1) << COL_W))) / BST_WORDS;
      if (room < c) c = room;
`else
      room = 0;
`endif
      expBl.push_back(c - 1 + room * 0);
      expAddr.push_back(addr);
      addr   = (addr + longint'(c * BST_WORDS)) % (longint'(1) << ADDR_W);
      remain = remain - c;
    end
  endtask

  // Compare a finished transfer against the model. Each request issues one
  // cycle after the first free WAIT cycle. WAIT starts at acknowledge and
  // again two cycles after each pulse. h_done follows the last pulse by two
  // cycles.
  task automatic checkAgainstModel(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                                   input logic wr, input string tag);
    int x;
    int expCyc;
    int waitStart;
    buildModel(a, int'(len));
    checkOutput({tag, ".ackCount"}, 64'(ackCyc.size()), 64'd1);
    if (ackCyc.size() > 0) begin
      checkOutput({tag, ".ackCycle"}, 64'(ackCyc[0]), 64'(reqCyc + 1));
      checkOutput({tag, ".ackBusy"}, 64'(ackBusy[0]), 64'd1);
    end
    checkOutput({tag, ".pulseCount"}, 64'(pulses.size()), 64'(expBl.size()));
    waitStart = reqCyc + 1;
    expCyc    = reqCyc;
    for (int i = 0; i < expBl.size(); i++) begin
      x = waitStart;
      while (busyAt.exists(x) && busyAt[x]) x++;
      expCyc = x + 1;
      if (i < pulses.size()) begin
        checkOutput($sformatf("%s.p%0d.bl", tag, i), 64'(pulses[i].bl), 64'(expBl[i]));
        checkOutput($sformatf("%s.p%0d.addr", tag, i), 64'(pulses[i].addr), 64'(expAddr[i]));
        checkOutput($sformatf("%s.p%0d.wrN", tag, i), 64'(pulses[i].wrN), 64'(wr));
        checkOutput($sformatf("%s.p%0d.cycle", tag, i), 64'(pulses[i].cyc), 64'(expCyc));
      end
      waitStart = expCyc + 2;
    end
    checkOutput({tag, ".doneCount"}, 64'(doneCyc.size()), 64'd1);
    if (doneCyc.size() > 0) begin
      checkOutput({tag, ".doneCycle"}, 64'(doneCyc[0]), 64'(expCyc + 2));
      checkOutput({tag, ".doneBusy"}, 64'(doneBusy[0]), 64'd0);
    end
  endtask

  // All externally visible registers at their cleared values
  task automatic checkClearedOutputs(input string tag);
    checkOutput({tag, ".mcb_bb"}, 64'(mcb_bb), 64'd0);
    checkOutput({tag, ".mcb_wr_n"}, 64'(mcb_wr_n), 64'd1);
    checkOutput({tag, ".mcb_bl"}, 64'(mcb_bl), 64'd0);
    checkOutput({tag, ".mcb_addr"}, 64'(mcb_addr), 64'd0);
    checkOutput({tag, ".h_ack"}, 64'(h_ack), 64'd0);
    checkOutput({tag, ".h_done"}, 64'(h_done), 64'd0);
    checkOutput({tag, ".h_busy"}, 64'(h_busy), 64'd0);
  endtask

  // Abort a three-request write in the POST cycle after its first pulse
  task automatic clearMidTransfer(input bit useRst, input string tag);
    int budget;
    clearLogs();
    mcb_busy = 1'b0;
    h_req    = 1'b1;
    h_addr   = 22'h000100;
    h_len    = 8'd9;
    h_wr_n   = 1'b0;
    step();
    h_req  = 1'b0;
    budget = 0;
    while (pulses.size() == 0 && budget < 50) begin
      step();
      budget++;
    end
    checkOutput({tag, ".firstPulse"}, 64'(pulses.size()), 64'd1);
    step();
    if (useRst) mcb_rst_n = 1'b0;
    else        mcb_sclr_n = 1'b0;
    step();
    mcb_rst_n  = 1'b1;
    mcb_sclr_n = 1'b1;
    checkClearedOutputs(tag);
    repeat (20) step();
    checkOutput({tag, ".noMorePulses"}, 64'(pulses.size()), 64'd1);
    checkOutput({tag, ".noDone"}, 64'(doneCyc.size()), 64'd0);
  endtask

  // A second request is raised in WAIT and held until it is accepted. It
  // must not disturb the first transfer and must be acknowledged the cycle
  // after the first h_done.
  task automatic requestWhileBusy();
    int budget;
    clearLogs();
    h_req    = 1'b1;
    h_addr   = 22'h000200;
    h_len    = 8'd5;
    h_wr_n   = 1'b0;
    reqCyc   = cyc;
    mcb_busy = 1'b1;
    step();
    h_req  = 1'b1;
    h_addr = 22'h003000;
    h_len  = 8'd0;
    h_wr_n = 1'b1;
    budget = 0;
    while (ackCyc.size() < 2 && budget < 200) begin
      mcb_busy = (cyc < reqCyc + 4);
      step();
      budget++;
    end
    h_req = 1'b0;
    while (doneCyc.size() < 2 && budget < 400) begin
      mcb_busy = 1'b0;
      step();
      budget++;
    end
    checkOutput("rwb.ackCount", 64'(ackCyc.size()), 64'd2);
    checkOutput("rwb.doneCount", 64'(doneCyc.size()), 64'd2);
    if (ackCyc.size() == 2 && doneCyc.size() == 2) begin
      checkOutput("rwb.ack0", 64'(ackCyc[0]), 64'(reqCyc + 1));
      checkOutput("rwb.ack1", 64'(ackCyc[1]), 64'(doneCyc[0] + 1));
    end
    checkOutput("rwb.pulseCount", 64'(pulses.size()), 64'd3);
    if (pulses.size() == 3) begin
      checkOutput("rwb.p0.cycle", 64'(pulses[0].cyc), 64'(reqCyc + 5));
      checkOutput("rwb.p0.bl", 64'(pulses[0].bl), 64'd3);
      checkOutput("rwb.p0.addr", 64'(pulses[0].addr), 64'h200);
      checkOutput("rwb.p1.bl", 64'(pulses[1].bl), 64'd1);
      checkOutput("rwb.p1.addr", 64'(pulses[1].addr), 64'h210);
      checkOutput("rwb.p1.wrN", 64'(pulses[1].wrN), 64'd0);
      checkOutput("rwb.p2.bl", 64'(pulses[2].bl), 64'd0);
      checkOutput("rwb.p2.addr", 64'(pulses[2].addr), 64'h3000);
      checkOutput("rwb.p2.wrN", 64'(pulses[2].wrN), 64'd1);
    end
  endtask

  // Main sequence: reset, directed table, corner sequences, random transfers
  initial begin
    logic [ADDR_W-1:0] rAddr;
    logic [LEN_W-1:0]  rLen;
    logic              rWr;

    mcb_rst_n  = 1'b0;
    mcb_sclr_n = 1'b1;
    h_req      = 1'b0;
    h_wr_n     = 1'b1;
    h_addr     = '0;
    h_len      = '0;
    mcb_busy   = 1'b0;

    // Directed transfers with hand-derived expectations
    vecs.push_back(vec_t'{22'h000100, 8'd9,   1'b1, 0, 3,  2'd3, 22'h000100, 2'd1, 22'h000120, 9});
    vecs.push_back(vec_t'{22'h000040, 8'd0,   1'b0, 5, 1,  2'd0, 22'h000040, 2'd0, 22'h000040, 8});
`ifdef MCF_ROW_SPLIT_EN
    vecs.push_back(vec_t'{22'h0000F8, 8'd3,   1'b1, 0, 2,  2'd1, 22'h0000F8, 2'd1, 22'h000100, 6});
    vecs.push_back(vec_t'{22'h0000FC, 8'd3,   1'b1, 0, 2,  2'd0, 22'h0000FC, 2'd2, 22'h000100, 6});
`else
    vecs.push_back(vec_t'{22'h0000F8, 8'd3,   1'b1, 0, 1,  2'd3, 22'h0000F8, 2'd3, 22'h0000F8, 3});
    vecs.push_back(vec_t'{22'h0000FC, 8'd3,   1'b1, 0, 1,  2'd3, 22'h0000FC, 2'd3, 22'h0000FC, 3});
`endif
    vecs.push_back(vec_t'{22'h3FFFF0, 8'd255, 1'b1, 0, 64, 2'd3, 22'h3FFFF0, 2'd3, 22'h0003E0, 192});
    vecs.push_back(vec_t'{22'h0001F0, 8'd6,   1'b0, 2, 2,  2'd3, 22'h0001F0, 2'd2, 22'h000200, 8});

    repeat (3) step();
    checkClearedOutputs("reset");
    mcb_rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].addr, vecs[i].len, vecs[i].wrN, vecs[i].busyCycles, 1'b0);
      checkOutput($sformatf("vec%0d.pulses", i), 64'(pulses.size()), 64'(vecs[i].expPulses));
      if (pulses.size() > 0) begin
        checkOutput($sformatf("vec%0d.firstBl", i), 64'(pulses[0].bl), 64'(vecs[i].expFirstBl));
        checkOutput($sformatf("vec%0d.firstAddr", i), 64'(pulses[0].addr), 64'(vecs[i].expFirstAddr));
        checkOutput($sformatf("vec%0d.firstWrN", i), 64'(pulses[0].wrN), 64'(vecs[i].wrN));
        checkOutput($sformatf("vec%0d.lastBl", i), 64'(pulses[pulses.size()-1].bl), 64'(vecs[i].expLastBl));
        checkOutput($sformatf("vec%0d.lastAddr", i), 64'(pulses[pulses.size()-1].addr), 64'(vecs[i].expLastAddr));
      end
      if (ackCyc.size() > 0 && doneCyc.size() > 0) begin
        checkOutput($sformatf("vec%0d.ackToDone", i), 64'(doneCyc[0] - ackCyc[0]), 64'(vecs[i].expAckToDone));
      end
      checkAgainstModel(vecs[i].addr, vecs[i].len, vecs[i].wrN, $sformatf("vec%0d", i));
    end

    clearMidTransfer(1'b0, "sclr");
    clearMidTransfer(1'b1, "rst");
    requestWhileBusy();
    repeat (2) step();

    for (int t = 0; t < 24; t++) begin
      rAddr = ADDR_W'($urandom) & ~ADDR_W'(BST_WORDS - 1);
      rLen  = (t % 6 == 5) ? LEN_W'($urandom_range(0, 255)) : LEN_W'($urandom_range(0, 20));
      rWr   = 1'($urandom_range(0, 1));
      applyStimulus(rAddr, rLen, rWr, 0, 1'b1);
      checkAgainstModel(rAddr, rLen, rWr, $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
